// File: rtl/secp256k1_point_check_if.sv
// secp256k1_point_check_if
//   Request/verdict bundle between the point source and the curve check.
//   master : start, x1, y1 out; busy, done, on_curve, x_out, y_out in
//   slave  : the mirror image, used by secp256k1_point_check
interface secp256k1_point_check_if #(
  parameter int WIDTH = 256
);
  logic             start;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] y1;
  logic             busy;
  logic             done;
  logic             on_curve;
  logic [WIDTH-1:0] x_out;
  logic [WIDTH-1:0] y_out;

  modport master (
    output start, x1, y1,
    input  busy, done, on_curve, x_out, y_out
  );

  modport slave (
    input  start, x1, y1,
    output busy, done, on_curve, x_out, y_out
  );
endinterface

// File: rtl/secp256k1_point_check.sv
// secp256k1_point_check
//   Input validation ahead of the secp256k1 scalar multiplier. Checks that
//   the affine point (x1,y1) satisfies y^2 == x^3 + B (mod P) using a single
//   bit-serial, MSB-first interleaved modular multiplier, then presents the
//   latched point and the verdict for one cycle on done.
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   io     : slave side of secp256k1_point_check_if
//            start/x1/y1 in; busy/done/on_curve/x_out/y_out out
// Configuration
//   RANGE_CHECK_EN : when defined, x1 >= P or y1 >= P is rejected at
//                    acceptance (straight to DONE, on_curve=0, no multiply).
// Timing
//   Accepting edge = edge 0. SQX runs edges 1..W, CUBE W+1..2W,
//   SQY 2W+1..3W, CMP edge 3W+1, DONE edge 3W+2; done is high in the
//   following cycle, which is an IDLE cycle, so a held start is re-accepted
//   on edge 3W+3.
module secp256k1_point_check #(
  parameter int               WIDTH = 256,
  parameter logic [WIDTH-1:0] P     = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
  parameter logic [WIDTH-1:0] B     = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  secp256k1_point_check_if.slave io
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SQX, CUBE, SQY, CMP, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             oc_q, oc_d;

  // multiplier operand selection: a is the addend, b_bit the current
  // multiplier bit (CUBE multiplies t by x, so its bits come from x)
  logic [WIDTH-1:0] mul_a;
  logic             mul_bit;
  logic [WIDTH+1:0] pw, dbl, red1, sum;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH:0]   s_ext;
  logic [WIDTH-1:0] s_red;

  always_comb begin
    mul_a   = x_q;
    mul_bit = x_q[idx_q];
    case (state_q)
      CUBE:    begin mul_a = t_q; mul_bit = x_q[idx_q]; end
      SQY:     begin mul_a = y_q; mul_bit = y_q[idx_q]; end
      default: begin mul_a = x_q; mul_bit = x_q[idx_q]; end
    endcase

    // one interleaved step; acc < P on entry keeps every sum below 2P,
    // so a single conditional subtract restores the range each time
    pw       = {2'b00, P};
    dbl      = {1'b0, acc_q, 1'b0};
    red1     = (dbl >= pw) ? (dbl - pw) : dbl;
    sum      = red1 + (mul_bit ? {2'b00, mul_a} : '0);
    acc_step = (sum >= pw) ? WIDTH'(sum - pw) : WIDTH'(sum);

    // x^3 + B reduced once; t < P and B < P so one subtract suffices
    s_ext = {1'b0, t_q} + {1'b0, B};
    s_red = (s_ext >= {1'b0, P}) ? WIDTH'(s_ext - {1'b0, P}) : WIDTH'(s_ext);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    t_d     = t_q;
    x_d     = x_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    oc_d    = oc_q;

    case (state_q)
      IDLE: begin
        if (io.start) begin
          x_d    = io.x1;
          y_d    = io.y1;
          acc_d  = '0;
          idx_d  = IDX_TOP;
          busy_d = 1'b1;
`ifdef RANGE_CHECK_EN
          if ((io.x1 >= P) || (io.y1 >= P)) begin
            state_d = DONE;
            oc_d    = 1'b0;
          end else begin
            state_d = SQX;
          end
`else
          state_d = SQX;
`endif
        end
      end
      SQX, CUBE, SQY: begin
        acc_d = acc_step;
        idx_d = idx_q - 1'b1;
        if (idx_q == '0) begin
          idx_d = IDX_TOP;
          if (state_q == SQY) begin
            state_d = CMP;           // acc now holds y^2
          end else begin
            t_d     = acc_step;      // x^2, then x^3
            acc_d   = '0;
            state_d = (state_q == SQX) ? CUBE : SQY;
          end
        end
      end
      CMP: begin
        oc_d    = (s_red == acc_q);
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= IDX_TOP;
      acc_q   <= '0;
      t_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      oc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      t_q     <= t_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      oc_q    <= oc_d;
    end
  end

  assign io.busy     = busy_q;
  assign io.done     = done_q;
  assign io.on_curve = oc_q;
  assign io.x_out    = x_q;
  assign io.y_out    = y_q;

endmodule
